// File: rtl/task_answer_pkg.sv
// task_answer_pkg: shared states, constants and descriptor type for the answer packetizer
package task_answer_pkg;
  typedef enum logic [2:0] {IDLE, HDR_SIZE, HDR_LAT, PAYLOAD, DRAIN} state_e;
  localparam int HEADER_BYTES = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int ANSWER_WIDTH = 32;
  typedef struct packed {
    logic [31:0] size;
    logic [31:0] latency;
  } desc_t;
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/answer_sync_fifo.sv
// answer_sync_fifo: first-word-fall-through synchronous FIFO; a write into a full FIFO succeeds only alongside a read
module answer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic do_wr, do_rd;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];
  assign do_rd = rd_i && !empty_o;
  assign do_wr = wr_i && (!full_o || do_rd);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/task_answer_packetizer.sv
// task_answer_packetizer: buffers task answers and frames each as size/latency header plus trimmed payload bytes
module task_answer_packetizer
  import task_answer_pkg::*;
#(
  parameter int FIFO_DEPTH = 256,
  parameter int DESC_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_answer_valid,
  input  logic [31:0] i_answer_data,
  input  logic        i_answer_last,
  input  logic [31:0] i_answer_size_in_bytes,
  input  logic [31:0] i_answer_latency,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_overflow
);
  logic word_full, word_empty, word_pop, desc_full, desc_empty, desc_pop, slot, pay_end, head_last;
  logic [ANSWER_WIDTH:0] head;
  desc_t desc_in, desc_head, desc_q;
  state_e state_q;
  logic [31:0] byte_cnt_q;
  logic [1:0] byte_idx_q;
  logic tx_valid_q, overflow_q;
  logic [7:0] tx_data_q;
  assign desc_in = '{size: i_answer_size_in_bytes, latency: i_answer_latency};
  answer_sync_fifo #(.WIDTH(ANSWER_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_word (
    .clk_i(i_clk), .rst_i(i_rst), .wr_i(i_answer_valid), .wdata_i({i_answer_last, i_answer_data}),
    .rd_i(word_pop), .rdata_o(head), .full_o(word_full), .empty_o(word_empty)
  );
  answer_sync_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc (
    .clk_i(i_clk), .rst_i(i_rst), .wr_i(i_answer_valid && i_answer_last), .wdata_i(desc_in),
    .rd_i(desc_pop), .rdata_o(desc_head), .full_o(desc_full), .empty_o(desc_empty)
  );
  // the output register can take a new byte when empty or being drained this cycle
  assign slot = !tx_valid_q || i_tx_ready;
  assign head_last = head[ANSWER_WIDTH];
  assign pay_end = byte_cnt_q == 32'd1 || (byte_idx_q == 2'd3 && head_last);
  assign desc_pop = state_q == IDLE && !desc_empty && slot;
  assign word_pop = !word_empty && ((state_q == PAYLOAD && slot && (byte_idx_q == 2'd3 || pay_end)) || state_q == DRAIN);
  assign o_tx_data = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_overflow = overflow_q;
  assign o_busy = state_q != IDLE || !desc_empty || !word_empty;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      byte_cnt_q <= '0;
      byte_idx_q <= '0;
      desc_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if ((i_answer_valid && word_full && !word_pop) || (i_answer_valid && i_answer_last && desc_full && !desc_pop))
        overflow_q <= 1'b1;
      case (state_q)
        IDLE: if (slot) begin
          tx_valid_q <= !desc_empty;
          if (!desc_empty) begin
            desc_q <= desc_head;
            byte_cnt_q <= desc_head.size;
            tx_data_q <= desc_head.size[7:0];
            byte_idx_q <= 2'd1;
            state_q <= HDR_SIZE;
          end
        end
        HDR_SIZE: if (slot) begin
          tx_data_q <= byte_of(desc_q.size, byte_idx_q);
          byte_idx_q <= byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) state_q <= HDR_LAT;
        end
        HDR_LAT: if (slot) begin
          tx_data_q <= byte_of(desc_q.latency, byte_idx_q);
          byte_idx_q <= byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) state_q <= desc_q.size != 0 ? PAYLOAD : DRAIN;
        end
        PAYLOAD: if (slot) begin
          tx_valid_q <= !word_empty;
          if (!word_empty) begin
            tx_data_q <= byte_of(head[ANSWER_WIDTH-1:0], byte_idx_q);
            byte_cnt_q <= byte_cnt_q - 32'd1;
            byte_idx_q <= pay_end ? 2'd0 : byte_idx_q + 1'b1;
            if (pay_end) state_q <= head_last ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (slot) tx_valid_q <= 1'b0;
          if (!word_empty && head_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_task_answer_packetizer.sv
// tb_task_answer_packetizer: directed frames into a byte scoreboard checked by an independent monitor
module tb_task_answer_packetizer;
  logic i_clk, i_rst, i_answer_valid, i_answer_last, i_tx_ready, o_tx_valid, o_busy, o_overflow;
  logic [31:0] i_answer_data, i_answer_size_in_bytes, i_answer_latency;
  logic [7:0] o_tx_data;
  logic [7:0] exp_q[$];
  int n_chk = 0, n_fail = 0, rx_cnt = 0, rdy_mode = 0;

  task_answer_packetizer #(.FIFO_DEPTH(4), .DESC_DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_answer_valid(i_answer_valid), .i_answer_data(i_answer_data),
    .i_answer_last(i_answer_last), .i_answer_size_in_bytes(i_answer_size_in_bytes),
    .i_answer_latency(i_answer_latency), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .o_busy(o_busy), .o_overflow(o_overflow)
  );

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic hold_v;
    logic [7:0] hold_d, e;
    hold_v = 0;
    hold_d = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) hold_v = 0;
      else begin
        if (hold_v) begin
          chk("hold_valid", {31'b0, o_tx_valid}, 32'd1);
          chk("hold_data", {24'b0, o_tx_data}, {24'b0, hold_d});
        end
        if (o_tx_valid && i_tx_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h expected none", o_tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_byte", {24'b0, o_tx_data}, {24'b0, e});
          end
          rx_cnt++;
        end
        hold_v = o_tx_valid && !i_tx_ready;
        hold_d = o_tx_data;
      end
    end
  end

  initial begin
    i_tx_ready = 1;
    forever begin
      @(posedge i_clk);
      #1;
      i_tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? !i_tx_ready : 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic last, input logic [31:0] size, input logic [31:0] lat);
    i_answer_valid = 1;
    i_answer_data = d;
    i_answer_last = last;
    i_answer_size_in_bytes = size;
    i_answer_latency = lat;
    @(posedge i_clk);
    #1;
    i_answer_valid = 0;
    i_answer_last = 0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge i_clk);
      k++;
    end
    chk({name, "_timeout"}, exp_q.size(), 0);
    repeat (6) @(posedge i_clk);
    #1;
    chk({name, "_busy"}, {31'b0, o_busy}, 0);
    chk({name, "_valid"}, {31'b0, o_tx_valid}, 0);
  endtask

  task automatic do_reset();
    i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    i_answer_valid = 0;
    i_answer_data = 0;
    i_answer_last = 0;
    i_answer_size_in_bytes = 0;
    i_answer_latency = 0;
    do_reset();
    chk("rst_valid", {31'b0, o_tx_valid}, 0);
    chk("rst_data", {24'b0, o_tx_data}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_overflow", {31'b0, o_overflow}, 0);

    exp_q = {exp_q, 8'h08, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(32'h44332211, 0, 0, 0);
    send(32'h88776655, 1, 8, 32'h10);
    wait_done("basic");

    exp_q = {exp_q, 8'h05, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(32'h44332211, 0, 0, 0);
    send(32'h88776655, 1, 5, 32'h10);
    wait_done("trim");

    rdy_mode = 1;
    exp_q = {exp_q, 8'h08, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(32'h44332211, 0, 0, 0);
    send(32'h88776655, 1, 8, 32'h10);
    wait_done("backpressure");
    rdy_mode = 0;

    exp_q = {exp_q, 8'h00, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send(32'h01010101, 0, 0, 0);
    send(32'h02020202, 0, 0, 0);
    send(32'h03030303, 1, 0, 32'hDEADBEEF);
    wait_done("zero_size");

    rdy_mode = 2;
    repeat (2) @(posedge i_clk);
    #1;
    for (int i = 0; i < 4; i++) send(32'hA0 + i, 0, 0, 0);
    chk("ovf_before_drop", {31'b0, o_overflow}, 0);
    send(32'hA4, 0, 0, 0);
    send(32'hA5, 1, 24, 32'h1);
    chk("ovf_set", {31'b0, o_overflow}, 1);
    repeat (5) @(posedge i_clk);
    #1;
    chk("ovf_sticky", {31'b0, o_overflow}, 1);
    do_reset();
    rdy_mode = 0;
    chk("ovf_cleared", {31'b0, o_overflow}, 0);
    chk("ovf_rst_busy", {31'b0, o_busy}, 0);

    exp_q = {exp_q, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
             8'h04, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send(32'hDDCCBBAA, 1, 4, 32'h1);
    send(32'h04030201, 1, 4, 32'h2);
    wait_done("b2b");

    rx_cnt = 0;
    exp_q = {exp_q, 8'h08, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(32'h44332211, 0, 0, 0);
    send(32'h88776655, 1, 8, 32'h10);
    k = 0;
    while (rx_cnt < 10 && k < 500) begin
      @(posedge i_clk);
      k++;
    end
    chk("mid_rx_count", rx_cnt, 10);
    #1;
    i_rst = 1;
    @(posedge i_clk);
    #1;
    chk("mid_rst_valid", {31'b0, o_tx_valid}, 0);
    exp_q.delete();
    i_rst = 0;
    exp_q = {exp_q, 8'h03, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h21, 8'h43, 8'h65};
    send(32'h87654321, 1, 3, 32'h12345678);
    wait_done("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
